rx_data_buffer: RTL and testbench

RX_DATA_BUFFER -- requirements
Module: rx_data_buffer

---
 rtl/rx_data_buffer.sv | 121 ++++++++++++
 tb/tb_rx_data_buffer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_data_buffer.sv
// Receive-side byte FIFO for a USB function core, with a status FSM that tracks
// the DATA packet being captured and whether a complete packet is held.
module rx_data_buffer #(
    parameter int DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [2:0]              rx_packet,
    input  logic                    store_rx_data,
    input  logic [7:0]              rx_data_in,
    input  logic                    get_rx_data,
    input  logic                    flush,
    output logic [7:0]              rx_data_out,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    rx_active,
    output logic                    rx_data_ready,
    output logic                    rx_error,
    output logic                    overflow
);
    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW:0]     FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0]     OCC_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [AW-1:0]   PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [2:0]      PKT_IDLE  = 3'd0;
    localparam logic [2:0]      PKT_DATA0 = 3'd3;
    localparam logic [2:0]      PKT_DATA1 = 3'd4;
    localparam logic [2:0]      PKT_ERROR = 3'd7;

    typedef enum logic [1:0] {IDLE, RECEIVING, COMPLETE, ERROR} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ_next;
    logic          do_read;
    logic          do_write;
    logic          drop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // A full FIFO still accepts a byte when a read frees a slot in the same cycle.
    assign do_read  = get_rx_data && (occupancy != '0);
    assign do_write = store_rx_data && (state == RECEIVING) && ((occupancy != FULL) || do_read);
    assign drop     = store_rx_data && (state == RECEIVING) && (occupancy == FULL) && !do_read;

    always_comb begin
        occ_next = occupancy;
        if (do_write && !do_read)
            occ_next = occupancy + OCC_ONE;
        else if (do_read && !do_write)
            occ_next = occupancy - OCC_ONE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_read)
                rd_ptr <= next_ptr(rd_ptr);
            occupancy <= occ_next;
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Storage is deliberately left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_write && !flush)
            mem[wr_ptr] <= rx_data_in;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_packet == PKT_DATA0 || rx_packet == PKT_DATA1)
                        state <= RECEIVING;
                    else if (rx_packet == PKT_ERROR)
                        state <= ERROR;
                end
                RECEIVING: begin
                    if (rx_packet == PKT_IDLE)
                        state <= COMPLETE;
                    else if (rx_packet == PKT_ERROR)
                        state <= ERROR;
                end
                COMPLETE: begin
                    if (rx_packet == PKT_ERROR)
                        state <= ERROR;
                    else if (occ_next == '0)
                        state <= IDLE;
                end
                default: state <= ERROR;
            endcase
        end
    end

    assign rx_data_out   = (occupancy != '0) ? mem[rd_ptr] : 8'h00;
    assign rx_active     = (state == RECEIVING);
    assign rx_data_ready = (state == COMPLETE) && (occupancy != '0);
    assign rx_error      = (state == ERROR);

endmodule

// File: tb/tb_rx_data_buffer.sv
// Self-checking bench for rx_data_buffer: directed scenarios plus a randomized
// run compared against a queue-based model of the packet buffer.
module tb_rx_data_buffer;
    localparam int DEPTH = 64;
    localparam int M_IDLE = 0, M_RECV = 1, M_DONE = 2, M_ERR = 3;
    localparam logic [2:0] P_IDLE = 3'd0, P_OUT = 3'd1, P_IN = 3'd2, P_D0 = 3'd3;
    localparam logic [2:0] P_D1 = 3'd4, P_ACK = 3'd5, P_NAK = 3'd6, P_ERR = 3'd7;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] rx_packet = 3'd0;
    logic       store_rx_data = 1'b0;
    logic [7:0] rx_data_in = 8'h00;
    logic       get_rx_data = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] rx_data_out;
    logic [6:0] occupancy;
    logic       rx_active, rx_data_ready, rx_error, overflow;
    logic [18:0] observed;

    int vectors = 0;
    int miscompares = 0;

    byte unsigned q[$];
    int           mode;
    bit           ovf;

    always #5 clk = ~clk;

    assign observed = {occupancy, rx_data_out, rx_active, rx_data_ready, rx_error, overflow};

    rx_data_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rx_packet     (rx_packet),
        .store_rx_data (store_rx_data),
        .rx_data_in    (rx_data_in),
        .get_rx_data   (get_rx_data),
        .flush         (flush),
        .rx_data_out   (rx_data_out),
        .occupancy     (occupancy),
        .rx_active     (rx_active),
        .rx_data_ready (rx_data_ready),
        .rx_error      (rx_error),
        .overflow      (overflow)
    );

    task automatic model_reset();
        q.delete();
        mode = M_IDLE;
        ovf  = 1'b0;
    endtask

    // Packet-level model: a byte queue plus the current packet phase.
    task automatic model_step();
        bit rd, wr;
        int after;
        if (flush) begin
            model_reset();
            return;
        end
        rd = get_rx_data && (q.size() > 0);
        wr = store_rx_data && (mode == M_RECV) && (q.size() < DEPTH || rd);
        if (store_rx_data && mode == M_RECV && q.size() == DEPTH && !rd)
            ovf = 1'b1;
        after = q.size() - int'(rd) + int'(wr);
        case (mode)
            M_IDLE: if (rx_packet == P_D0 || rx_packet == P_D1) mode = M_RECV;
                    else if (rx_packet == P_ERR) mode = M_ERR;
            M_RECV: if (rx_packet == P_IDLE) mode = M_DONE;
                    else if (rx_packet == P_ERR) mode = M_ERR;
            M_DONE: if (rx_packet == P_ERR) mode = M_ERR;
                    else if (after == 0) mode = M_IDLE;
            default: ;
        endcase
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(rx_data_in);
    endtask

    function automatic logic [18:0] expected();
        logic [7:0] head;
        head = (q.size() > 0) ? q[0] : 8'h00;
        return {7'(q.size()), head, mode == M_RECV, (mode == M_DONE) && (q.size() > 0),
                mode == M_ERR, ovf};
    endfunction

    task automatic tick(input logic [2:0] pkt, input logic st, input logic [7:0] d,
                        input logic gt, input logic fl);
        rx_packet = pkt; store_rx_data = st; rx_data_in = d; get_rx_data = gt; flush = fl;
        @(posedge clk);
        model_step();
        #1;
        store_rx_data = 1'b0; get_rx_data = 1'b0; flush = 1'b0;
    endtask

    task automatic cyc(input logic [2:0] pkt);
        tick(pkt, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic put(input logic [2:0] pkt, input logic [7:0] d);
        tick(pkt, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic take(input logic [2:0] pkt);
        tick(pkt, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_flush();
        tick(P_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #2;
        vectors++;
        if (observed !== 19'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", observed, 19'h0);
        end
        n_rst = 1'b1;
        model_reset();
        cyc(P_IDLE);
        vectors++;
        if (observed !== 19'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle_hold: got %h expected %h", observed, 19'h0);
        end
    endtask

    task automatic test_basic_packet();
        cyc(P_D0);
        put(P_D0, 8'hA5);
        vectors++;
        if ({occupancy, rx_data_out, rx_active} !== {7'd1, 8'hA5, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL basic_first_byte: got %h expected %h",
                     {occupancy, rx_data_out, rx_active}, {7'd1, 8'hA5, 1'b1});
        end
        put(P_D0, 8'h3C);
        cyc(P_IDLE);
        vectors++;
        if ({occupancy, rx_data_out, rx_data_ready, rx_active} !== {7'd2, 8'hA5, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL basic_complete: got %h expected %h",
                     {occupancy, rx_data_out, rx_data_ready, rx_active}, {7'd2, 8'hA5, 1'b1, 1'b0});
        end
        take(P_IDLE);
        vectors++;
        if ({occupancy, rx_data_out} !== {7'd1, 8'h3C}) begin
            miscompares++;
            $display("[TB] FAIL basic_second_read: got %h expected %h",
                     {occupancy, rx_data_out}, {7'd1, 8'h3C});
        end
        take(P_IDLE);
        vectors++;
        if ({occupancy, rx_data_out, rx_data_ready} !== {7'd0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL basic_drained: got %h expected %h",
                     {occupancy, rx_data_out, rx_data_ready}, {7'd0, 8'h00, 1'b0});
        end
        // Back in IDLE, so a new DATA code must be accepted immediately.
        cyc(P_D1);
        vectors++;
        if (rx_active !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_back_to_idle: got %b expected %b", rx_active, 1'b1);
        end
        cyc(P_IDLE);
        cyc(P_IDLE);
        cyc(P_OUT); cyc(P_IN); cyc(P_ACK); cyc(P_NAK);
        vectors++;
        if ({rx_active, rx_error, rx_data_ready} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL token_codes_stay_idle: got %b expected %b",
                     {rx_active, rx_error, rx_data_ready}, 3'b000);
        end
        cyc(P_IDLE);
    endtask

    task automatic test_overflow();
        byte unsigned exp[$];
        logic [7:0] d;
        cyc(P_D1);
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom);
            exp.push_back(d);
            put(P_D1, d);
        end
        put(P_D1, 8'hEE);
        vectors++;
        if ({occupancy, overflow} !== {7'd64, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL overflow_full: got %h expected %h", {occupancy, overflow}, {7'd64, 1'b1});
        end
        cyc(P_IDLE);
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (rx_data_out !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL overflow_read[%0d]: got %h expected %h", i, rx_data_out, exp[i]);
            end
            take(P_IDLE);
        end
        vectors++;
        if ({occupancy, overflow, rx_data_ready} !== {7'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL overflow_sticky: got %h expected %h",
                     {occupancy, overflow, rx_data_ready}, {7'd0, 1'b1, 1'b0});
        end
        do_flush();
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL overflow_flush_clear: got %b expected %b", overflow, 1'b0);
        end
    endtask

    task automatic test_back_to_back_full();
        byte unsigned exp[$];
        logic [7:0] d;
        cyc(P_D0);
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom);
            exp.push_back(d);
            put(P_D0, d);
        end
        tick(P_D0, 1'b1, 8'h77, 1'b1, 1'b0);
        void'(exp.pop_front());
        exp.push_back(8'h77);
        vectors++;
        if ({occupancy, overflow} !== {7'd64, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL full_rw_occupancy: got %h expected %h", {occupancy, overflow}, {7'd64, 1'b0});
        end
        cyc(P_IDLE);
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (rx_data_out !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL full_rw_read[%0d]: got %h expected %h", i, rx_data_out, exp[i]);
            end
            take(P_IDLE);
        end
        vectors++;
        if (occupancy !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL full_rw_drained: got %0d expected %0d", occupancy, 0);
        end
    endtask

    task automatic test_error();
        cyc(P_D0);
        put(P_D0, 8'h11);
        put(P_D0, 8'h22);
        cyc(P_ERR);
        vectors++;
        if ({rx_error, rx_active, occupancy} !== {1'b1, 1'b0, 7'd2}) begin
            miscompares++;
            $display("[TB] FAIL error_entry: got %h expected %h",
                     {rx_error, rx_active, occupancy}, {1'b1, 1'b0, 7'd2});
        end
        put(P_ERR, 8'h33);
        put(P_D0, 8'h44);
        put(P_IDLE, 8'h55);
        vectors++;
        if ({rx_error, occupancy, overflow} !== {1'b1, 7'd2, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL error_stores_ignored: got %h expected %h",
                     {rx_error, occupancy, overflow}, {1'b1, 7'd2, 1'b0});
        end
        do_flush();
        vectors++;
        if ({rx_error, occupancy} !== {1'b0, 7'd0}) begin
            miscompares++;
            $display("[TB] FAIL error_flush: got %h expected %h", {rx_error, occupancy}, {1'b0, 7'd0});
        end
        cyc(P_ERR);
        vectors++;
        if (rx_error !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL idle_error_code: got %b expected %b", rx_error, 1'b1);
        end
        do_flush();
    endtask

    task automatic test_flush_priority();
        cyc(P_D0);
        put(P_D0, 8'h01);
        put(P_D0, 8'h02);
        put(P_D0, 8'h03);
        tick(P_D0, 1'b1, 8'h99, 1'b1, 1'b1);
        vectors++;
        if (observed !== 19'h0) begin
            miscompares++;
            $display("[TB] FAIL flush_priority: got %h expected %h", observed, 19'h0);
        end
        cyc(P_IDLE);
    endtask

    task automatic test_reset_midpacket();
        cyc(P_D1);
        for (int i = 0; i < 10; i++)
            put(P_D1, 8'(i + 8'h40));
        cyc(P_IDLE);
        vectors++;
        if ({occupancy, rx_data_ready} !== {7'd10, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL rst_pre_state: got %h expected %h", {occupancy, rx_data_ready}, {7'd10, 1'b1});
        end
        n_rst = 1'b0;
        #1;
        vectors++;
        if (observed !== 19'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_async_outputs: got %h expected %h", observed, 19'h0);
        end
        model_reset();
        #1;
        n_rst = 1'b1;
        cyc(P_IDLE);
        vectors++;
        if (observed !== 19'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_after_release: got %h expected %h", observed, 19'h0);
        end
    endtask

    task automatic test_random();
        logic [2:0] pkts [12] = '{P_IDLE, P_IDLE, P_IDLE, P_D0, P_D0, P_D1, P_D1,
                                  P_OUT, P_IN, P_ACK, P_NAK, P_ERR};
        logic [2:0] pkt;
        pkt = P_IDLE;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0)
                pkt = pkts[$urandom_range(0, 11)];
            tick(pkt, 1'($urandom_range(0, 1)), 8'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0);
            vectors++;
            if (observed !== expected()) begin
                miscompares++;
                $display("[TB] FAIL random[%0d]: got %h expected %h", i, observed, expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_overflow();
        test_back_to_back_full();
        test_error();
        test_flush_priority();
        test_reset_midpacket();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
